sseg_scan: RTL and testbench

- Time-multiplexing scanner that sits directly upstream of the 7-segment decoder (sseg).
- Holds an N-digit hex value and cycles through the digits at a fixed refresh rate.
- For each digit it drives the decoder's en/dp/number inputs and a one-hot digit-select bus to the display common pins.
- Inserts a blanking gap between digits to suppress ghosting; new values apply only at frame boundaries, so a frame never shows torn data.

---
 rtl/sseg_pkg.sv | 29 ++
 rtl/sseg_tick_div.sv | 24 ++
 rtl/sseg_scan.sv | 130 +++++++++++++
 tb/tb_sseg_scan.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared types and helpers for the 7-segment digit scanner.
// Holds the phase enum, the leading-zero mask helper and the parameter legality check.
package sseg_pkg;

    typedef enum logic {PH_BLANK, PH_SHOW} phase_t;

    localparam int MAX_DIGITS = 8;
    localparam int VW         = 4 * MAX_DIGITS;

    function automatic bit params_ok(input int n, input int div, input int blank);
        return (n >= 1) && (n <= MAX_DIGITS) && (div >= 2) && (blank >= 0) && (blank < div);
    endfunction

    // Bit d set when nibbles d..n-1 are all zero; bit 0 is never set.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [VW-1:0] v, input int n);
        logic [MAX_DIGITS-1:0] m;
        logic                  zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int d = MAX_DIGITS - 1; d >= 1; d--) begin
            if (d < n) begin
                zero_above = zero_above & (v[d*4 +: 4] == 4'h0);
                m[d]       = zero_above;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/sseg_tick_div.sv
// Per-digit period counter: counts 0..DIV-1 and flags the last cycle and the blanking window.
module sseg_tick_div #(
    parameter int DIV   = 50000,
    parameter int BLANK = 16,
    parameter int CW    = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic wrap,
    output logic in_blank
);

    logic [CW-1:0] cnt;

    assign wrap     = (cnt == CW'(DIV - 1));
    assign in_blank = (cnt < CW'(BLANK));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt <= '0;
        else if (wrap) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/sseg_scan.sv
// Time-multiplexed N-digit hex scanner feeding the sseg decoder and the digit commons.
// Values are staged on load and promoted to the shadow set only at frame boundaries.
module sseg_scan
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_en,
    output logic                    sseg_en,
    output logic                    sseg_dp,
    output logic [3:0]              sseg_number,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

    if (!params_ok(NUM_DIGITS, REFRESH_DIV, BLANK_CYCLES)) begin : g_bad_params
        $error("sseg_scan: illegal NUM_DIGITS/REFRESH_DIV/BLANK_CYCLES");
    end

    typedef struct packed {
        logic [NUM_DIGITS-1:0] sel;
        logic                  en;
        logic                  dp;
        logic [3:0]            num;
        logic                  done;
    } out_t;

    logic wrap, in_blank;

    sseg_tick_div #(.DIV(REFRESH_DIV), .BLANK(BLANK_CYCLES), .CW(CW)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .wrap     (wrap),
        .in_blank (in_blank)
    );

    // Enables are held inverted so the all-zero reset state means every digit is lit.
    logic [NUM_DIGITS-1:0][3:0] stg_val, sh_val;
    logic [NUM_DIGITS-1:0]      stg_dp, sh_dp, stg_dark, sh_dark;
    logic                       pending;
    logic [IW-1:0]              idx, idx_d;
    out_t                       out_q, out_d;
    phase_t                     phase;
    logic                       boundary;
    logic [MAX_DIGITS-1:0]      lz_all;
    logic [NUM_DIGITS-1:0]      lz;

    assign boundary = wrap && (idx == LAST);
    assign lz_all   = lz_mask(VW'(sh_val), NUM_DIGITS);
    assign lz       = lz_all[NUM_DIGITS-1:0];

    always_comb begin
        out_d = '0;
        idx_d = idx;
        phase = in_blank ? PH_BLANK : PH_SHOW;
        if (sh_dark[idx]) phase = PH_BLANK;
        if (phase == PH_SHOW) begin
            out_d.sel = NUM_DIGITS'(1) << idx;
            out_d.dp  = sh_dp[idx];
            if (!(lz_en && lz[idx])) begin
                out_d.en  = 1'b1;
                out_d.num = sh_val[idx];
            end
        end
        out_d.done = boundary;
        if (wrap) idx_d = (idx == LAST) ? '0 : idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            idx   <= '0;
        end else begin
            out_q <= out_d;
            idx   <= idx_d;
        end
    end

    // A load landing on the boundary edge bypasses staging so it shows next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_val  <= '0;
            stg_dp   <= '0;
            stg_dark <= '0;
            sh_val   <= '0;
            sh_dp    <= '0;
            sh_dark  <= '0;
            pending  <= 1'b0;
        end else begin
            if (load) begin
                stg_val  <= value;
                stg_dp   <= dp_mask;
                stg_dark <= ~digit_en;
            end
            if (boundary) begin
                pending <= 1'b0;
                if (load) begin
                    sh_val  <= value;
                    sh_dp   <= dp_mask;
                    sh_dark <= ~digit_en;
                end else if (pending) begin
                    sh_val  <= stg_val;
                    sh_dp   <= stg_dp;
                    sh_dark <= stg_dark;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    assign digit_sel   = out_q.sel;
    assign sseg_en     = out_q.en;
    assign sseg_dp     = out_q.dp;
    assign sseg_number = out_q.num;
    assign frame_done  = out_q.done;

endmodule

// File: tb/tb_sseg_scan.sv
// Directed bench for sseg_scan with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_sseg_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  digit_en = '0;
    logic        lz_en = 1'b0;
    logic        sseg_en, sseg_dp, frame_done;
    logic [3:0]  sseg_number, digit_sel;

    sseg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .value       (value),
        .dp_mask     (dp_mask),
        .digit_en    (digit_en),
        .lz_en       (lz_en),
        .sseg_en     (sseg_en),
        .sseg_dp     (sseg_dp),
        .sseg_number (sseg_number),
        .digit_sel   (digit_sel),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        int          cyc;
        bit          ld;
        logic [15:0] val;
        logic [3:0]  dpm;
        logic [3:0]  den;
        bit          lz;
        logic [3:0]  sel;
        bit          en;
        bit          dp;
        logic [3:0]  num;
        bit          done;
    } vec_t;

    vec_t vecs[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    function automatic logic [10:0] pk(logic [3:0] sel, bit en, bit dp, logic [3:0] num, bit done);
        return {sel, en, dp, num, done};
    endfunction

    function automatic logic [10:0] act();
        return {digit_sel, sseg_en, sseg_dp, sseg_number, frame_done};
    endfunction

    task automatic chk(input string name, input logic [10:0] got, input logic [10:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got sel/en/dp/num/done=%h expected %h", name, got, exp);
    endtask

    task automatic chk_bit(input string name, input bit got, input bit exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic add(bit r, int c, bit l, logic [15:0] v, logic [3:0] dpm, logic [3:0] den, bit lz,
                       logic [3:0] sel, bit en, bit dp, logic [3:0] num, bit done);
        vec_t t;
        t.rst = r; t.cyc = c; t.ld = l; t.val = v; t.dpm = dpm; t.den = den; t.lz = lz;
        t.sel = sel; t.en = en; t.dp = dp; t.num = num; t.done = done;
        vecs.push_back(t);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        load  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        bit done_bad, sel4_seen, dig2_lit;

        // rst cyc ld value dpm den lz | sel en dp num done
        add(1,  0, 0, 16'h0,    4'h0, 4'h0, 0,  4'h0, 0, 0, 4'h0, 0);
        add(0,  1, 0, 16'h0,    4'h0, 4'h0, 0,  4'h0, 0, 0, 4'h0, 0);
        add(0,  2, 0, 16'h0,    4'h0, 4'h0, 0,  4'h0, 0, 0, 4'h0, 0);
        add(0,  3, 0, 16'h0,    4'h0, 4'h0, 0,  4'h1, 1, 0, 4'h0, 0);
        add(0,  5, 1, 16'h1A2F, 4'h2, 4'hF, 0,  4'h1, 1, 0, 4'h0, 0);
        add(0,  8, 0, 16'h0,    4'h0, 4'h0, 0,  4'h1, 1, 0, 4'h0, 0);
        add(0,  9, 0, 16'h0,    4'h0, 4'h0, 0,  4'h0, 0, 0, 4'h0, 0);
        add(0, 11, 0, 16'h0,    4'h0, 4'h0, 0,  4'h2, 1, 0, 4'h0, 0);
        add(0, 31, 0, 16'h0,    4'h0, 4'h0, 0,  4'h8, 1, 0, 4'h0, 0);
        add(0, 32, 0, 16'h0,    4'h0, 4'h0, 0,  4'h8, 1, 0, 4'h0, 1);
        add(0, 33, 0, 16'h0,    4'h0, 4'h0, 0,  4'h0, 0, 0, 4'h0, 0);
        add(0, 35, 0, 16'h0,    4'h0, 4'h0, 0,  4'h1, 1, 0, 4'hF, 0);
        add(0, 40, 0, 16'h0,    4'h0, 4'h0, 0,  4'h1, 1, 0, 4'hF, 0);
        add(0, 41, 0, 16'h0,    4'h0, 4'h0, 0,  4'h0, 0, 0, 4'h0, 0);
        add(0, 43, 0, 16'h0,    4'h0, 4'h0, 0,  4'h2, 1, 1, 4'h2, 0);
        add(0, 51, 0, 16'h0,    4'h0, 4'h0, 0,  4'h4, 1, 0, 4'hA, 0);
        add(0, 59, 0, 16'h0,    4'h0, 4'h0, 0,  4'h8, 1, 0, 4'h1, 0);
        add(0, 64, 0, 16'h0,    4'h0, 4'h0, 0,  4'h8, 1, 0, 4'h1, 1);
        // load on the boundary edge bypasses staging
        add(1,  0, 0, 16'h0,    4'h0, 4'h0, 0,  4'h0, 0, 0, 4'h0, 0);
        add(0, 32, 1, 16'h0042, 4'h0, 4'hF, 0,  4'h8, 1, 0, 4'h0, 1);
        add(0, 34, 0, 16'h0,    4'h0, 4'h0, 0,  4'h0, 0, 0, 4'h0, 0);
        add(0, 35, 0, 16'h0,    4'h0, 4'h0, 0,  4'h1, 1, 0, 4'h2, 0);
        add(0, 40, 0, 16'h0,    4'h0, 4'h0, 0,  4'h1, 1, 0, 4'h2, 0);
        add(0, 43, 0, 16'h0,    4'h0, 4'h0, 0,  4'h2, 1, 0, 4'h4, 0);
        add(0, 51, 0, 16'h0,    4'h0, 4'h0, 0,  4'h4, 1, 0, 4'h0, 0);
        // leading-zero suppression, then lz_en dropped live
        add(1,  0, 0, 16'h0,    4'h0, 4'h0, 1,  4'h0, 0, 0, 4'h0, 0);
        add(0,  3, 0, 16'h0,    4'h0, 4'h0, 1,  4'h1, 1, 0, 4'h0, 0);
        add(0, 11, 0, 16'h0,    4'h0, 4'h0, 1,  4'h2, 0, 0, 4'h0, 0);
        add(0, 32, 1, 16'h0005, 4'h8, 4'hF, 1,  4'h8, 0, 0, 4'h0, 1);
        add(0, 35, 0, 16'h0,    4'h0, 4'h0, 1,  4'h1, 1, 0, 4'h5, 0);
        add(0, 43, 0, 16'h0,    4'h0, 4'h0, 1,  4'h2, 0, 0, 4'h0, 0);
        add(0, 51, 0, 16'h0,    4'h0, 4'h0, 1,  4'h4, 0, 0, 4'h0, 0);
        add(0, 57, 0, 16'h0,    4'h0, 4'h0, 1,  4'h0, 0, 0, 4'h0, 0);
        add(0, 59, 0, 16'h0,    4'h0, 4'h0, 1,  4'h8, 0, 1, 4'h0, 0);
        add(0, 75, 0, 16'h0,    4'h0, 4'h0, 0,  4'h2, 1, 0, 4'h0, 0);
        // digit 2 disabled
        add(1,  0, 0, 16'h0,    4'h0, 4'h0, 0,  4'h0, 0, 0, 4'h0, 0);
        add(0,  5, 1, 16'h4321, 4'h0, 4'hB, 0,  4'h1, 1, 0, 4'h0, 0);
        add(0, 43, 0, 16'h0,    4'h0, 4'h0, 0,  4'h2, 1, 0, 4'h2, 0);
        add(0, 51, 0, 16'h0,    4'h0, 4'h0, 0,  4'h0, 0, 0, 4'h0, 0);
        add(0, 56, 0, 16'h0,    4'h0, 4'h0, 0,  4'h0, 0, 0, 4'h0, 0);
        add(0, 59, 0, 16'h0,    4'h0, 4'h0, 0,  4'h8, 1, 0, 4'h4, 0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            while (cyc < vecs[i].cyc - 1) step();
            lz_en = vecs[i].lz;
            if (vecs[i].cyc > 0) begin
                load     = vecs[i].ld;
                value    = vecs[i].val;
                dp_mask  = vecs[i].dpm;
                digit_en = vecs[i].den;
                step();
                load = 1'b0;
            end
            chk($sformatf("vec%0d@cyc%0d", i, vecs[i].cyc), act(),
                pk(vecs[i].sel, vecs[i].en, vecs[i].dp, vecs[i].num, vecs[i].done));
        end

        // frame_done cadence and a fully dark digit 2 across a whole frame
        lz_en = 1'b0;
        do_reset();
        done_bad = 0; sel4_seen = 0; dig2_lit = 0;
        for (int c = 1; c <= 64; c++) begin
            load     = (c == 5);
            value    = 16'h4321;
            dp_mask  = 4'h0;
            digit_en = 4'b1011;
            step();
            load = 1'b0;
            if (frame_done != ((c == 32) || (c == 64))) done_bad = 1;
            if (c >= 33 && digit_sel == 4'b0100) sel4_seen = 1;
            if (c >= 49 && c <= 56 && (digit_sel != 4'h0 || sseg_en)) dig2_lit = 1;
        end
        chk_bit("frame_done_only_at_32_64", done_bad, 1'b0);
        chk_bit("disabled_digit_never_selected", sel4_seen, 1'b0);
        chk_bit("disabled_period_blank", dig2_lit, 1'b0);

        // asynchronous reset in the middle of a SHOW phase
        do_reset();
        while (cyc < 31) step();
        load = 1'b1; value = 16'h7777; dp_mask = 4'h0; digit_en = 4'hF;
        step();
        load = 1'b0;
        while (cyc < 52) step();
        chk("pre_reset_digit2", act(), pk(4'h4, 1, 0, 4'h7, 0));
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", act(), pk(4'h0, 0, 0, 4'h0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        step();
        chk("restart_cyc1_blank", act(), pk(4'h0, 0, 0, 4'h0, 0));
        step();
        chk("restart_cyc2_blank", act(), pk(4'h0, 0, 0, 4'h0, 0));
        step();
        chk("restart_cyc3_shadow_cleared", act(), pk(4'h1, 1, 0, 4'h0, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
